// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues instruction-memory reads and fills IF/ID.
// Optional macro MISALIGN_TRAP_EN: misaligned redirect targets halt and raise Misalign.
module fetch_pc_unit #(
    parameter int                PC_W     = 9,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Halt,
    input  logic             Resume,
    input  logic             Imem_Rdy,
    input  logic [31:0]      Imem_Data,
    output logic             Imem_Req,
    output logic [PC_W-1:0]  Imem_Addr,
    output logic [PC_W-1:0]  IfId_PC,
    output logic [31:0]      IfId_Inst,
    output logic             IfId_Valid,
    output logic             Flush,
    output logic             Halted
`ifdef MISALIGN_TRAP_EN
    ,output logic            Misalign
`endif
);

    typedef enum logic [1:0] {FETCH, WAIT_MEM, HALTED} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            bad_target;
    logic            resume_ok;
    logic            unused_brpc;

    function automatic logic [PC_W-1:0] pc_inc4(input logic [PC_W-1:0] p);
        return p + PC_W'(4);
    endfunction

    function automatic logic [PC_W-1:0] align_target(input logic [31:0] t);
        return {t[PC_W-1:2], 2'b00};
    endfunction

`ifdef MISALIGN_TRAP_EN
    assign bad_target = (BrPC[1:0] != 2'b00);
    assign resume_ok  = Resume && !Misalign;
`else
    assign bad_target = 1'b0;
    assign resume_ok  = Resume;
`endif

    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    assign Imem_Addr = pc;
    assign Imem_Req  = reset && (state != HALTED) && !Stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            IfId_PC    <= '0;
            IfId_Inst  <= NOP_INST;
            IfId_Valid <= 1'b0;
            Flush      <= 1'b0;
            Halted     <= 1'b0;
        end else begin
            Flush <= 1'b0;
            if (state == HALTED) begin
                if (resume_ok) begin
                    state  <= FETCH;
                    pc     <= pc_inc4(pc);
                    Halted <= 1'b0;
                end
            end else if (PcSel && (Halt || bad_target)) begin
                // Halt request or trapped target: PC stays on the halting instruction's slot
                state      <= HALTED;
                Halted     <= 1'b1;
                IfId_Valid <= 1'b0;
                IfId_Inst  <= NOP_INST;
                Flush      <= 1'b1;
            end else if (PcSel) begin
                // Redirect wins over stall and drops any same-cycle memory response
                pc         <= align_target(BrPC);
                state      <= FETCH;
                IfId_Valid <= 1'b0;
                IfId_Inst  <= NOP_INST;
                Flush      <= 1'b1;
            end else if (Stall) begin
                state <= state;
            end else if (Imem_Rdy) begin
                IfId_Inst  <= Imem_Data;
                IfId_PC    <= pc;
                IfId_Valid <= 1'b1;
                pc         <= pc_inc4(pc);
                state      <= FETCH;
            end else begin
                state      <= WAIT_MEM;
                IfId_Valid <= 1'b0;
                IfId_Inst  <= NOP_INST;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            Misalign <= 1'b0;
        else if ((state != HALTED) && PcSel && !Halt && bad_target)
            Misalign <= 1'b1;
    end
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Consumes the branch unit's redirect outputs (BrPC, PcSel, Halt) and owns the program counter.
- Issues instruction-memory read requests and fills the IF/ID pipeline register.
- Handles redirect flushes, hazard stalls, a wait-state instruction-memory handshake, and a halt/resume state machine.
- Sits between the branch unit (EX stage) and instruction memory / IF/ID.

Parameters:
PC_W, 9, PC width in bits; byte address; wraps modulo 2^PC_W
RESET_PC, 0, PC value loaded on reset (PC_W bits, word aligned)
NOP_INST, 32'h00000013, instruction placed in IfId_Inst on bubble/flush (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
Stall  in  1  hazard stall: hold PC and IF/ID
PcSel  in  1  redirect request from branch unit
BrPC  in  32  redirect target; bits [31:PC_W] ignored
Halt  in  1  halt qualifier, valid only with PcSel
Resume  in  1  leave HALTED
Imem_Rdy  in  1  instruction memory data valid this cycle
Imem_Data  in  32  instruction word
Imem_Req  out  1  read request
Imem_Addr  out  PC_W  read address (= PC)
IfId_PC  out  PC_W  PC of the captured instruction
IfId_Inst  out  32  captured instruction
IfId_Valid  out  1  IF/ID holds a real instruction
Flush  out  1  one-cycle pulse on redirect
Halted  out  1  high while in HALTED

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC; state=FETCH.
  - IfId_PC=0, IfId_Inst=NOP_INST, IfId_Valid=0.
  - Flush=0, Halted=0, Imem_Req=0 (registered outputs).
- States: FETCH, WAIT_MEM, HALTED.
- Combinational outputs:
  - Imem_Addr=PC.
  - Imem_Req=(state!=HALTED) && !Stall && !reset_active.
- Priority each cycle, highest first: PcSel&Halt > PcSel > Stall > memory handshake.
- PcSel=1, Halt=1:
  - PC held; state<=HALTED.
  - IfId_Valid<=0, IfId_Inst<=NOP_INST, Flush<=1.
- PcSel=1, Halt=0 (redirect):
  - PC<=BrPC[PC_W-1:0] with bits [1:0] forced 0; state<=FETCH.
  - IfId_Valid<=0, IfId_Inst<=NOP_INST, Flush<=1 for exactly one cycle.
  - A same-cycle Imem_Rdy response is discarded.
  - Redirect overrides Stall.
- Stall=1 (no PcSel):
  - PC, IF/ID contents and state held; Imem_Req=0.
  - Any Imem_Rdy pulse is ignored.
- FETCH/WAIT_MEM, Imem_Req=1, Imem_Rdy=1:
  - IfId_Inst<=Imem_Data, IfId_PC<=PC, IfId_Valid<=1.
  - PC<=PC+4 (mod 2^PC_W); state<=FETCH.
- FETCH, Imem_Req=1, Imem_Rdy=0:
  - state<=WAIT_MEM; IfId_Valid<=0 (bubble); PC held.
- WAIT_MEM, Imem_Rdy=0: remain; request stays asserted; IfId_Valid stays 0.
- HALTED:
  - Imem_Req=0; Halted=1; PcSel/Stall ignored.
  - Resume=1 -> state<=FETCH, PC<=PC+4, Halted<=0 next cycle.
- Flush deasserts the cycle after any redirect unless another redirect occurs.
- Throughput with Imem_Rdy always 1: one instruction per cycle; first valid IfId appears 1 cycle after reset release.
- Wrap: PC=2^PC_W-4 increments to 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output Misalign (1 bit, reset 0).
  - A redirect with BrPC[1:0]!=0 enters HALTED with PC held and sets Misalign=1.
  - Misalign is sticky until reset; Resume is ignored while Misalign=1.
- Undefined: port absent; misaligned targets are silently aligned by clearing bits [1:0].

Test Plan:
- Reset release, Imem_Rdy=1, words 0xA,0xB -> IfId_PC 0,4 with Valid=1 on consecutive cycles; Flush=0.
- At PC=8, PcSel=1, BrPC=0x40 -> Flush=1 for one cycle, IfId_Valid=0, IfId_Inst=0x00000013; next capture has IfId_PC=0x40.
- Imem_Rdy low 3 cycles at PC=0x10 -> state WAIT_MEM, Imem_Req held, Valid=0 for 3 cycles; then Inst captured with IfId_PC=0x10, PC=0x14.
- Stall=1 and PcSel=1 (BrPC=0x20) in same cycle -> redirect taken, PC=0x20; Stall alone 2 cycles -> PC and IF/ID unchanged, Imem_Req=0.
- PcSel=1,Halt=1 at PC=0x30 -> Halted=1, Imem_Req=0 until Resume; Resume -> fetch from 0x34; PC=0x1FC increments to 0x000.
- MISALIGN_TRAP_EN defined: redirect BrPC=0x42 -> Misalign=1, Halted=1, Resume ignored; undefined: fetch from 0x40.
